ram_4096x32: RTL and testbench
==============================

RAM_4096X32 -- requirements
Module: ram_4096x32

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 32, giving the word width in bits.
REQ-002 The block SHALL have a parameter ADDR_W, default 12, giving the address width in bits; depth is 2**ADDR_W (4096) words.
REQ-003 The block SHALL have a parameter RDW_NEW, default 0, selecting same-address read-during-write behaviour (0 = old data, 1 = new data).
REQ-004 The block SHALL have a parameter OUT_REG, default 0, which adds an extra output register stage when set to 1.
REQ-005 The block SHALL have a port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have a port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have a port data, input, DATA_W bits: the write data.
REQ-008 The block SHALL have a port wraddress, input, ADDR_W bits: the write address.
REQ-009 The block SHALL have a port wren, input, 1 bit: the write enable.
REQ-010 The block SHALL have a port rdaddress, input, ADDR_W bits: the read address.
REQ-011 The block SHALL have a port rden, input, 1 bit: the read enable.
REQ-012 The block SHALL have a port q, output, DATA_W bits: the registered read data.
REQ-013 Clocking and reset are fixed: one clock, clock; reset is synchronous and active-high on port reset.

Function
REQ-014 The block SHALL be a simple dual-port memory: one write port and one independent read port, both in the clock domain.
REQ-015 Write: at a rising edge with wren=1 and reset=0, the block SHALL store data into mem[wraddress]; with wren=0 memory is unchanged.
REQ-016 Read: at a rising edge with rden=1, the block SHALL load q with mem[rdaddress]; read latency is 1 cycle for OUT_REG=0 and 2 cycles for OUT_REG=1.
REQ-017 With rden=0, the block SHALL hold q at its previous value; with OUT_REG=1 the second stage follows the first stage unconditionally.
REQ-018 Same-address read and write in one cycle: with RDW_NEW=0, q SHALL receive the pre-write content; with RDW_NEW=1, q SHALL receive data.
REQ-019 Reads and writes at different addresses in the same cycle SHALL proceed independently and without interference.
REQ-020 Addresses SHALL be used unsigned over the full 0..2**ADDR_W-1 range, with no wrap or bounds logic inside the block.
REQ-021 Memory contents SHALL be 0 after configuration (initialised array); a location that has never been written reads as 0.
REQ-022 The block SHALL have no handshake and no backpressure; every enabled access completes in its cycle.

Reset
REQ-023 While reset=1, q and the OUT_REG stage register SHALL clear to 0 at the clock edge.
REQ-024 While reset=1, writes SHALL be suppressed and memory contents SHALL be retained, not cleared.
REQ-025 While reset=1, reads SHALL be suppressed.
REQ-026 On the first edge after reset deasserts, the block SHALL operate normally.
REQ-027 Reset asserted mid-read SHALL force q to 0; the pending read is discarded.

Structure
REQ-028 The default width and depth constants (DATA_W=32, ADDR_W=12) SHALL live in a shared package, ram_pkg.
REQ-029 The storage array SHALL be coded so synthesis infers block RAM (no reset on the array).
REQ-030 The output pipeline register SHALL be the one natural sub-module, ram_out_stage, instantiated only when OUT_REG=1.

Verification
REQ-031 Write/read-back: write 0xDEADBEEF to address 0x005, then read 0x005 with rden=1 -> q=0xDEADBEEF one cycle later (OUT_REG=0).
REQ-032 Hold: after REQ-031, drop rden and change rdaddress to 0x006 -> q stays 0xDEADBEEF.
REQ-033 Read-during-write: mem[0x010]=0x11111111, then write 0x22222222 to 0x010 while reading 0x010 -> q=0x11111111 (RDW_NEW=0); rerun with RDW_NEW=1 -> q=0x22222222.
REQ-034 Boundaries: write addresses 0x000 and 0xFFF with distinct values -> each reads back correctly; an unwritten address 0x123 reads 0.
REQ-035 Reset mid-operation: with q=0xDEADBEEF, assert reset for 1 cycle with wren=1 to 0x005 and data=0 -> q=0; a later read of 0x005 still returns 0xDEADBEEF.
REQ-036 Streaming: write 0..99 to addresses 0..99 on consecutive cycles while reading the previous address -> q tracks with 1-cycle latency, and 2-cycle latency with OUT_REG=1.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared defaults for the simple dual-port RAM and its output stage.
package ram_pkg;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 12;

    function automatic int ram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/ram_out_stage.sv
// Optional second read-data register; follows its input every cycle and clears on reset.
module ram_out_stage
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_4096x32.sv
// Simple dual-port RAM: one write port, one read port, registered read data,
// selectable read-during-write behaviour and optional extra output register.
module ram_4096x32
    import ram_pkg::*;
#(
    parameter int DATA_W  = RAM_DATA_W,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter bit RDW_NEW = 1'b0,
    parameter bit OUT_REG = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic              rden,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = ram_depth(ADDR_W);

    // No reset on the array so it maps onto block RAM; contents start at zero.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rd_q;
    logic              bypass;

    assign bypass = RDW_NEW && wren && (wraddress == rdaddress);

    always_ff @(posedge clock) begin
        if (wren && !reset) begin
            mem[wraddress] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= '0;
        end else if (rden) begin
            rd_q <= bypass ? data : mem[rdaddress];
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            ram_out_stage #(.DATA_W(DATA_W)) u_out_stage (
                .clock (clock),
                .reset (reset),
                .d     (rd_q),
                .q     (q)
            );
        end else begin : g_no_out_reg
            assign q = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_4096x32.sv
// Scoreboard bench for ram_4096x32: three instances (old-data RDW, new-data RDW,
// extra output register) share one stimulus stream; expected q values are queued per instance.
module tb_ram_4096x32;

    typedef struct packed {
        int          due;
        int          id;
        logic [31:0] val;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic [11:0] wraddress;
    logic        wren;
    logic [11:0] rdaddress;
    logic        rden;
    logic [31:0] q0, q1, q2;

    int   cyc_n = 0;
    int   total = 0;
    int   bad = 0;
    int   step_id = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc_n <= cyc_n + 1;

    ram_4096x32 #(.RDW_NEW(1'b0), .OUT_REG(1'b0)) dut_old (
        .clock(clock), .reset(reset), .data(data), .wraddress(wraddress), .wren(wren),
        .rdaddress(rdaddress), .rden(rden), .q(q0));
    ram_4096x32 #(.RDW_NEW(1'b1), .OUT_REG(1'b0)) dut_new (
        .clock(clock), .reset(reset), .data(data), .wraddress(wraddress), .wren(wren),
        .rdaddress(rdaddress), .rden(rden), .q(q1));
    ram_4096x32 #(.RDW_NEW(1'b0), .OUT_REG(1'b1)) dut_reg (
        .clock(clock), .reset(reset), .data(data), .wraddress(wraddress), .wren(wren),
        .rdaddress(rdaddress), .rden(rden), .q(q2));

    task automatic compare(input int d, input logic [31:0] act, input exp_t e);
        total++;
        if (act !== e.val || e.due != cyc_n) begin
            bad++;
            $display("FAIL step%0d dut%0d: got=%h want=%h (cycle %0d, due %0d)",
                     e.id, d, act, e.val, cyc_n, e.due);
        end
    endtask

    // Monitor: pop every expectation that has come due and compare against q.
    always @(negedge clock) begin
        while (sb0.size() > 0 && sb0[0].due <= cyc_n) compare(0, q0, sb0.pop_front());
        while (sb1.size() > 0 && sb1[0].due <= cyc_n) compare(1, q1, sb1.pop_front());
        while (sb2.size() > 0 && sb2[0].due <= cyc_n) compare(2, q2, sb2.pop_front());
    end

    // e0/e1: q after this edge for the two unregistered instances;
    // e2: first-stage value for the registered instance, visible one edge later.
    task automatic step(input logic rst, input logic we, input logic [11:0] wa,
                        input logic [31:0] wd, input logic re, input logic [11:0] ra,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [2:0] m);
        reset     = rst;
        wren      = we;
        wraddress = wa;
        data      = wd;
        rden      = re;
        rdaddress = ra;
        step_id++;
        if (m[0]) sb0.push_back('{due: cyc_n + 1, id: step_id, val: e0});
        if (m[1]) sb1.push_back('{due: cyc_n + 1, id: step_id, val: e1});
        if (m[2]) sb2.push_back('{due: cyc_n + 2, id: step_id, val: e2});
        @(posedge clock);
        #1;
    endtask

    initial begin
        step(1, 0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 32'h0, 32'h0, 3'b111);
        step(1, 0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 32'h0, 32'h0, 3'b111);
        // write then read back, then hold with rden low
        step(0, 1, 12'h005, 32'hDEADBEEF, 0, 12'h000, 32'h0, 32'h0, 32'h0, 3'b111);
        step(0, 0, 12'h000, 32'h0, 1, 12'h005,
             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111);
        step(0, 0, 12'h000, 32'h0, 0, 12'h006,
             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111);
        // read-during-write on the same address
        step(0, 1, 12'h010, 32'h11111111, 0, 12'h006,
             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111);
        step(0, 1, 12'h010, 32'h22222222, 1, 12'h010,
             32'h11111111, 32'h22222222, 32'h11111111, 3'b111);
        step(0, 0, 12'h000, 32'h0, 1, 12'h010,
             32'h22222222, 32'h22222222, 32'h22222222, 3'b111);
        // address boundaries, independent write/read, unwritten location
        step(0, 1, 12'h000, 32'hA5A5A5A5, 0, 12'h010,
             32'h22222222, 32'h22222222, 32'h22222222, 3'b111);
        step(0, 1, 12'hFFF, 32'h5A5A5A5A, 1, 12'h000,
             32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b111);
        step(0, 1, 12'h001, 32'hCAFEF00D, 1, 12'hFFF,
             32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 3'b111);
        step(0, 0, 12'h000, 32'h0, 1, 12'h123, 32'h0, 32'h0, 32'h0, 3'b111);
        step(0, 0, 12'h000, 32'h0, 1, 12'h001,
             32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 3'b111);
        // reset mid-read with a suppressed write; second stage is cleared on the reset edge
        step(0, 0, 12'h000, 32'h0, 1, 12'h005,
             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b011);
        step(1, 1, 12'h005, 32'h0, 1, 12'h005, 32'h0, 32'h0, 32'h0, 3'b111);
        step(0, 0, 12'h000, 32'h0, 1, 12'h005,
             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111);
        // streaming: write i to address i while reading address i-1
        for (int i = 0; i < 100; i++) begin
            if (i == 0)
                step(0, 1, 12'(i), 32'(i), 0, 12'h000,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111);
            else
                step(0, 1, 12'(i), 32'(i), 1, 12'(i - 1),
                     32'(i - 1), 32'(i - 1), 32'(i - 1), 3'b111);
        end
        step(0, 0, 12'h000, 32'h0, 1, 12'd99, 32'd99, 32'd99, 32'd99, 3'b111);
        step(0, 0, 12'h000, 32'h0, 0, 12'h000, 32'd99, 32'd99, 32'd99, 3'b111);

        for (int k = 0; k < 10 && (sb0.size() + sb1.size() + sb2.size()) > 0; k++)
            @(posedge clock);
        if ((sb0.size() + sb1.size() + sb2.size()) > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", sb0.size() + sb1.size() + sb2.size());
        end
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
